// File: rtl/uart_pkg.sv
// Shared UART timing definitions: default widths, 64 MHz divisor constants and
// the priority decode used by the baud generator.
package uart_pkg;

    localparam int UART_DIV_W      = 16;
    localparam int UART_FRAC_W     = 4;
    localparam int UART_OVERSAMPLE = 16;

    // Smallest integer divisor that still leaves a low clock between os ticks.
    localparam int MIN_DIV_INT = 2;

    // 64 MHz system clock, 16x oversampling; fraction in 1/16 clock units.
    localparam int DIV_INT_9600    = 416;
    localparam int DIV_FRAC_9600   = 11;
    localparam int DIV_INT_115200  = 34;
    localparam int DIV_FRAC_115200 = 12;
    localparam int DIV_INT_1M      = 4;
    localparam int DIV_FRAC_1M     = 0;

    typedef enum logic [1:0] {
        PH_CLEAR = 2'd0,
        PH_IDLE  = 2'd1,
        PH_RUN   = 2'd2
    } phase_e;

    function automatic phase_e phase_sel(input logic sync_clear, input logic enable);
        if (sync_clear) begin
            return PH_CLEAR;
        end
        if (!enable) begin
            return PH_IDLE;
        end
        return PH_RUN;
    endfunction

endpackage

// File: rtl/frac_period_counter.sv
// Fractional os-period counter: integer counter plus phase accumulator, with a
// pending divisor that is swapped in only on a period boundary.
module frac_period_counter
    import uart_pkg::*;
#(
    parameter int DIV_W            = UART_DIV_W,
    parameter int FRAC_W           = UART_FRAC_W,
    parameter int DEFAULT_DIV_INT  = DIV_INT_9600,
    parameter int DEFAULT_DIV_FRAC = DIV_FRAC_9600
) (
    input  logic              clk,
    input  logic              rst,
    input  phase_e            phase,
    input  logic              load_ok,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_end,
    output logic              os_tick
);

    logic [DIV_W:0]      cnt_q, cnt_d;
    logic [FRAC_W-1:0]   acc_q, acc_d;
    logic [DIV_W-1:0]    act_int_q, act_int_d;
    logic [FRAC_W-1:0]   act_frac_q, act_frac_d;
    logic [DIV_W-1:0]    pend_int_q, pend_int_d;
    logic [FRAC_W-1:0]   pend_frac_q, pend_frac_d;
    logic                os_tick_q, os_tick_d;
    logic [FRAC_W:0]     acc_sum;
    logic [DIV_W:0]      last_cnt;

    always_comb begin
        // acc_q is the phase before this period's addition; its carry stretches
        // the current period by one clock.
        acc_sum  = {1'b0, acc_q} + {1'b0, act_frac_q};
        last_cnt = {1'b0, act_int_q} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]}
                   - {{DIV_W{1'b0}}, 1'b1};
        os_end   = (phase == PH_RUN) && (cnt_q == last_cnt);

        cnt_d       = cnt_q;
        acc_d       = acc_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        os_tick_d   = os_end;

        if (load_ok) begin
            pend_int_d  = div_int;
            pend_frac_d = div_frac;
        end

        case (phase)
            PH_CLEAR: begin
                cnt_d = '0;
                acc_d = '0;
            end
            PH_IDLE: begin
                cnt_d      = '0;
                acc_d      = '0;
                act_int_d  = pend_int_q;
                act_frac_d = pend_frac_q;
            end
            default: begin
                if (os_end) begin
                    cnt_d      = '0;
                    acc_d      = acc_sum[FRAC_W-1:0];
                    act_int_d  = pend_int_q;
                    act_frac_d = pend_frac_q;
                end else begin
                    cnt_d = cnt_q + (DIV_W+1)'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            act_int_q   <= DIV_W'(DEFAULT_DIV_INT);
            act_frac_q  <= FRAC_W'(DEFAULT_DIV_FRAC);
            pend_int_q  <= DIV_W'(DEFAULT_DIV_INT);
            pend_frac_q <= FRAC_W'(DEFAULT_DIV_FRAC);
            os_tick_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            os_tick_q   <= os_tick_d;
        end
    end

    assign os_tick = os_tick_q;

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: os tick from the period counter, plus bit
// position tracking for mid-bit and bit-rate ticks and divisor-load checking.
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int DIV_W            = UART_DIV_W,
    parameter int FRAC_W           = UART_FRAC_W,
    parameter int OVERSAMPLE       = UART_OVERSAMPLE,
    parameter int DEFAULT_DIV_INT  = DIV_INT_9600,
    parameter int DEFAULT_DIV_FRAC = DIV_FRAC_9600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              sync_clear,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              baud_tick,
    output logic              cfg_err
);

    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);

    phase_e           phase;
    logic             load_ok;
    logic             load_bad;
    logic             os_end;
    logic [IDX_W-1:0] os_idx_q, os_idx_d;
    logic             mid_tick_q, mid_tick_d;
    logic             baud_tick_q, baud_tick_d;
    logic             cfg_err_q, cfg_err_d;

    assign phase    = phase_sel(sync_clear, enable);
    assign load_ok  = div_load && (div_int >= DIV_W'(MIN_DIV_INT));
    assign load_bad = div_load && !load_ok;

    frac_period_counter #(
        .DIV_W            (DIV_W),
        .FRAC_W           (FRAC_W),
        .DEFAULT_DIV_INT  (DEFAULT_DIV_INT),
        .DEFAULT_DIV_FRAC (DEFAULT_DIV_FRAC)
    ) u_period (
        .clk      (clk),
        .rst      (rst),
        .phase    (phase),
        .load_ok  (load_ok),
        .div_int  (div_int),
        .div_frac (div_frac),
        .os_end   (os_end),
        .os_tick  (os_tick)
    );

    always_comb begin
        os_idx_d    = os_idx_q;
        mid_tick_d  = 1'b0;
        baud_tick_d = 1'b0;
        cfg_err_d   = cfg_err_q;

        if (load_ok) begin
            cfg_err_d = 1'b0;
        end else if (load_bad) begin
            cfg_err_d = 1'b1;
        end

        // os_end is the same-cycle strobe behind os_tick, so the registered
        // mid/baud ticks line up with the registered os tick.
        if (phase != PH_RUN) begin
            os_idx_d = '0;
        end else if (os_end) begin
            mid_tick_d  = (os_idx_q == IDX_MID);
            baud_tick_d = (os_idx_q == IDX_LAST);
            os_idx_d    = (os_idx_q == IDX_LAST) ? '0 : os_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            os_idx_q    <= '0;
            mid_tick_q  <= 1'b0;
            baud_tick_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            os_idx_q    <= os_idx_d;
            mid_tick_q  <= mid_tick_d;
            baud_tick_q <= baud_tick_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign mid_tick  = mid_tick_q;
    assign baud_tick = baud_tick_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: tick spacing, fractional averaging, loads,
// sync_clear and reset, with expected cycle counts worked out by hand.
module tb_baud_gen_frac;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        sync_clear;
    logic        os_tick;
    logic        mid_tick;
    logic        baud_tick;
    logic        cfg_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int e_ref;
    int c_ref;

    int os_q[$];
    int mid_q[$];
    int baud_q[$];

    // Period lengths for 416 + 11/16 starting from a cleared accumulator.
    int t1_len [16] = '{416, 417, 417, 416, 417, 417, 416, 417,
                        417, 416, 417, 417, 416, 417, 417, 417};

    baud_gen_frac dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .div_int    (div_int),
        .div_frac   (div_frac),
        .div_load   (div_load),
        .sync_clear (sync_clear),
        .os_tick    (os_tick),
        .mid_tick   (mid_tick),
        .baud_tick  (baud_tick),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (os_tick)   os_q.push_back(cyc);
        if (mid_tick)  mid_q.push_back(cyc);
        if (baud_tick) baud_q.push_back(cyc);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_os(input int n, input int budget);
        int k;
        k = 0;
        while (os_q.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (os_q.size() < n) check("os_tick_timeout", os_q.size(), n);
    endtask

    task automatic do_load(input int di, input int df);
        div_int  = 16'(di);
        div_frac = 4'(df);
        div_load = 1'b1;
        wait_edges(1);
        div_load = 1'b0;
    endtask

    task automatic clear_q();
        os_q.delete();
        mid_q.delete();
        baud_q.delete();
    endtask

    // Stop with enable low, load a divisor, then raise enable and note the
    // last idle edge as the time reference.
    task automatic restart_with(input int di, input int df);
        enable = 1'b0;
        wait_edges(1);
        do_load(di, df);
        wait_edges(1);
        clear_q();
        e_ref  = cyc;
        enable = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        div_int    = '0;
        div_frac   = '0;
        div_load   = 1'b0;
        sync_clear = 1'b0;
        wait_edges(3);
        check("rst_os_tick",   int'(os_tick),   0);
        check("rst_mid_tick",  int'(mid_tick),  0);
        check("rst_baud_tick", int'(baud_tick), 0);
        check("rst_cfg_err",   int'(cfg_err),   0);
        rst = 1'b0;
        wait_edges(2);

        // Default divisor over 16 os periods.
        clear_q();
        e_ref  = cyc;
        enable = 1'b1;
        wait_os(16, 7000);
        check("t1_first", os_q[0] - e_ref, t1_len[0]);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("t1_gap%0d", i), os_q[i] - os_q[i-1], t1_len[i]);
        end
        check("t1_total", os_q[15] - e_ref, 6667);
        check("t1_mid",   mid_q[0]  - e_ref, os_q[7]  - e_ref);
        check("t1_baud",  baud_q[0] - e_ref, os_q[15] - e_ref);

        // Integer divisor 4: os every 4, baud every 64, mid 32 after baud.
        restart_with(4, 0);
        wait_os(33, 300);
        check("t2_first",   os_q[0] - e_ref, 4);
        check("t2_gap",     os_q[1] - os_q[0], 4);
        check("t2_span",    os_q[32] - os_q[0], 128);
        check("t2_baud0",   baud_q[0] - e_ref, 64);
        check("t2_baud1",   baud_q[1] - baud_q[0], 64);
        check("t2_mid0",    mid_q[0] - e_ref, 32);
        check("t2_mid_aft", mid_q[1] - baud_q[0], 32);

        // Maximum rate.
        restart_with(2, 0);
        wait_os(8, 50);
        check("t2b_first", os_q[0] - e_ref, 2);
        check("t2b_span",  os_q[7] - os_q[0], 14);

        // Load 10 in the middle of a 6-clock period.
        restart_with(6, 0);
        wait_os(2, 50);
        wait_edges(2);
        do_load(10, 0);
        wait_os(5, 100);
        check("t3_gap1", os_q[1] - os_q[0], 6);
        check("t3_gap2", os_q[2] - os_q[1], 6);
        check("t3_gap3", os_q[3] - os_q[2], 10);
        check("t3_gap4", os_q[4] - os_q[3], 10);

        // Rejected load keeps spacing; a later valid load clears the error.
        wait_edges(2);
        do_load(1, 5);
        check("t4_err_set", int'(cfg_err), 1);
        wait_os(8, 100);
        check("t4_gap6", os_q[6] - os_q[5], 10);
        check("t4_gap7", os_q[7] - os_q[6], 10);
        do_load(3, 0);
        check("t4_err_clr", int'(cfg_err), 0);
        wait_os(10, 100);
        check("t4_gap8", os_q[8] - os_q[7], 10);
        check("t4_gap9", os_q[9] - os_q[8], 3);

        // sync_clear three clocks after an os tick.
        restart_with(8, 0);
        wait_os(2, 40);
        wait_edges(2);
        sync_clear = 1'b1;
        wait_edges(1);
        sync_clear = 1'b0;
        c_ref = cyc;
        check("t5_no_tick", int'(os_tick), 0);
        clear_q();
        wait_os(16, 200);
        check("t5_first", os_q[0] - c_ref, 8);
        check("t5_mid",   mid_q[0] - c_ref, 64);
        check("t5_baud",  baud_q[0] - c_ref, 128);
        check("t5_nbaud", baud_q.size(), 1);

        // Reset landing on a tick edge, then enable cycled.
        do_load(0, 0);
        check("t6_err_set", int'(cfg_err), 1);
        wait_os(17, 40);
        wait_edges(7);
        rst = 1'b1;
        wait_edges(1);
        check("t6_os_tick",   int'(os_tick),   0);
        check("t6_mid_tick",  int'(mid_tick),  0);
        check("t6_baud_tick", int'(baud_tick), 0);
        check("t6_cfg_err",   int'(cfg_err),   0);
        rst = 1'b0;
        wait_edges(5);
        enable = 1'b0;
        wait_edges(2);
        clear_q();
        e_ref  = cyc;
        enable = 1'b1;
        wait_os(1, 500);
        check("t6_first", os_q[0] - e_ref, 416);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Parametrised fractional baud-rate generator for the UART path. It replaces the fixed-divide prescaler. From a single system clock it produces an oversample tick, a mid-bit sample strobe and a bit-rate tick. The divisor is runtime-programmable with integer and fractional parts, so standard rates are hit without cumulative drift (for example 64 MHz / (9600·16) = 416.667). It feeds both the UART TX serialiser (baud_tick) and the RX sampler (os_tick, mid_tick, sync_clear).

## Interface
Parameters:
- DIV_W, 16: width of the integer divisor.
- FRAC_W, 4: width of the fractional divisor, in units of 1/2^FRAC_W clock.
- OVERSAMPLE, 16: os_ticks per bit. Must be even and ≥ 4.
- DEFAULT_DIV_INT, 416: active integer divisor after reset.
- DEFAULT_DIV_FRAC, 11: active fractional divisor after reset (≈0.6875).

Ports:
- clk, in, 1: system clock. This is the only clock.
- rst, in, 1: synchronous, active-high reset. It has priority over every other input.
- enable, in, 1: run when high. When low, all timing state is held cleared.
- div_int, in, DIV_W: new integer divisor, sampled on div_load.
- div_frac, in, FRAC_W: new fractional divisor, sampled on div_load.
- div_load, in, 1: one-cycle strobe that requests a divisor update.
- sync_clear, in, 1: restarts the phase. The RX uses it on start-bit detection.
- os_tick, out, 1: one-cycle oversample pulse.
- mid_tick, out, 1: one-cycle pulse at the mid-bit sample point.
- baud_tick, out, 1: one-cycle pulse per bit period.
- cfg_err, out, 1: sticky flag. Set when a load is rejected.

## Operation
- Active divisor: the os period is div_int + div_frac/2^FRAC_W clocks.
  - Each os period, a FRAC_W-bit accumulator adds div_frac.
  - If that addition carries out, the period just starting lasts div_int+1 clocks; otherwise it lasts div_int clocks.
  - The period counter is DIV_W+1 bits wide. No arithmetic wraps inside a period.
- os_idx counts os_ticks from 0 to OVERSAMPLE-1, then wraps to 0.
  - baud_tick coincides with the os_tick on which os_idx wraps from OVERSAMPLE-1 to 0.
  - mid_tick coincides with the os_tick on which os_idx goes from OVERSAMPLE/2-1 to OVERSAMPLE/2.
- Divisor load:
  - div_load with div_int ≥ 2 is accepted. The values are latched into a pending register and cfg_err is cleared.
  - If enable is high, the pending values become active at the next os period boundary, i.e. the clock after the next os_tick. The current period is never shortened or stretched.
  - If enable is low, the pending values become active on the next clock.
  - div_load with div_int < 2 is rejected. The active and pending divisors are unchanged and cfg_err is set.
  - A second load before the first is applied overwrites the pending values; only the last one is applied.
- Priority order: rst, then sync_clear, then enable-low, then normal counting.
  - sync_clear clears the counter, accumulator and os_idx. No tick is produced in that cycle.
  - sync_clear does not affect a pending divisor or cfg_err.
- When enable is low: counter, accumulator and os_idx are all 0, and all tick outputs are 0.

## Timing
- Reset values:
  - os_tick = 0, mid_tick = 0, baud_tick = 0, cfg_err = 0.
  - Active and pending divisors = DEFAULT_DIV_INT / DEFAULT_DIV_FRAC.
  - Counter, accumulator and os_idx = 0.
- All outputs are registered.
- After enable rises, or after a sync_clear cycle with enable high, the first os_tick is asserted exactly N clocks later, where N is the length of the first period.
  - The first period after a clear applies the carry of 0 + div_frac.
- Each tick is high for exactly one clock.
- With div_int = 2 and div_frac = 0, os_tick is high every other clock. This is the maximum rate.
- Over 2^FRAC_W os periods, the total is exactly 2^FRAC_W·div_int + div_frac clocks.
- If reset is asserted mid-period, the next cycle shows the reset values. No partial tick is produced.

## Structure
- Shared package `uart_pkg` holds:
  - DIV_W, FRAC_W and OVERSAMPLE defaults.
  - Named divisor constants for the 64 MHz system clock: 9600, 115200 and 1 Mbaud at 16× oversampling.
- Sub-module `frac_period_counter` contains the period counter, the fractional accumulator and the pending/active divisor registers. It outputs os_tick.
- The top level adds os_idx, mid_tick, baud_tick and the cfg_err logic.

## Test plan
- Reset defaults (416 + 11/16), enable held high for 16 os periods → exactly 6667 clocks in total, with os_tick gaps of 416 or 417 clocks only.
- div_int = 4, div_frac = 0, OVERSAMPLE = 16 → os_tick every 4 clocks, baud_tick every 64 clocks, mid_tick 32 clocks after each baud_tick.
- div_load with div_int = 10 issued mid-period of a div_int = 6 run → the current period still completes at 6 clocks; the following period is 10 clocks.
- div_load with div_int = 1 → cfg_err = 1 and the tick spacing is unchanged. A later load with div_int = 3 → cfg_err = 0.
- sync_clear pulsed 3 clocks after an os_tick, with div_int = 8 → no tick that cycle; next os_tick 8 clocks after the clear; os_idx restarts so that baud_tick follows 16 os_ticks later.
- rst asserted mid-period, then enable dropped and raised → all outputs 0 the cycle after rst, and the first os_tick exactly one period after enable rises.
